fir_output_requant: RTL



---
 rtl/fir_output_requant.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fir_output_requant.sv
// fir_output_requant: requantizes full-precision FIR results to the output
// sample width (round + saturate) and buffers them in a small FIFO.
// A valid/ready handshake feeds the downstream side. The FIR cannot be
// stalled, so samples that arrive while the FIFO is full are dropped and counted.
//
// Optional build macro FIR_REQUANT_CONV_ROUND_EN selects convergent rounding
// (round half to even). When it is not defined, rounding is round half toward +inf.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   in_valid, in_data  FIR result stream; one sample per cycle, no backpressure
//   out_valid          FIFO head is valid
//   out_ready          downstream takes the head this cycle
//   out_data           requantized sample at the FIFO head
//   fifo_level         current FIFO occupancy
//   sat_count          saturated samples (sticks at all-ones)
//   drop_count         samples dropped on full FIFO (sticks at all-ones)
module fir_output_requant #(
  parameter int unsigned DATA_IN_WIDTH  = 64,
  parameter int unsigned DATA_OUT_WIDTH = 16,
  parameter int unsigned SHIFT          = 31,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  input  logic [DATA_IN_WIDTH-1:0]              in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_OUT_WIDTH-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_level,
  output logic [CNT_WIDTH-1:0]                  sat_count,
  output logic [CNT_WIDTH-1:0]                  drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = DATA_IN_WIDTH + 1;

  localparam logic signed [SW-1:0] MAX_S =
    {{(SW-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_S =
    {{(SW-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};

  // Stage 1: sign-extend by one bit so adding the rounding constant cannot overflow
  logic signed [SW-1:0] in_ext;
  logic signed [SW-1:0] s1_next;
  logic signed [SW-1:0] s1_data;
  logic                 s1_v;

  assign in_ext = $signed({in_data[DATA_IN_WIDTH-1], in_data});

`ifdef FIR_REQUANT_CONV_ROUND_EN
  localparam logic [SHIFT-1:0] HALF_FRAC = SHIFT'(1) << (SHIFT - 1);

  logic signed [SW-1:0] trunc;
  logic [SHIFT-1:0]     frac;
  logic                 round_up;

  // Floor, then round up above one half, or at exactly one half when the floor is odd
  always_comb begin
    trunc    = in_ext >>> SHIFT;
    frac     = in_data[SHIFT-1:0];
    round_up = (frac > HALF_FRAC) || ((frac == HALF_FRAC) && trunc[0]);
    s1_next  = trunc + $signed({{(SW-1){1'b0}}, round_up});
  end
`else
  localparam logic signed [SW-1:0] HALF = SW'(1) << (SHIFT - 1);

  logic signed [SW-1:0] sum;

  // Add one half, then floor: rounds half toward +inf
  always_comb begin
    sum     = in_ext + HALF;
    s1_next = sum >>> SHIFT;
  end
`endif

  // Stage 2: clamp to the output range
  logic [DATA_OUT_WIDTH-1:0] s2_next;
  logic                      s2_sat_next;
  logic [DATA_OUT_WIDTH-1:0] s2_data;
  logic                      s2_v;
  logic                      s2_sat;

  always_comb begin
    s2_next     = s1_data[DATA_OUT_WIDTH-1:0];
    s2_sat_next = 1'b0;
    if (s1_data > MAX_S) begin
      s2_next     = MAX_S[DATA_OUT_WIDTH-1:0];
      s2_sat_next = 1'b1;
    end else if (s1_data < MIN_S) begin
      s2_next     = MIN_S[DATA_OUT_WIDTH-1:0];
      s2_sat_next = 1'b1;
    end
  end

  // Stage 3: FIFO with registered head, level and valid
  logic [DATA_OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr_nxt;
  logic [PW-1:0]             wr_ptr_nxt;
  logic                      full;
  logic                      rd;
  logic                      wr;
  logic                      drop;
  logic [DATA_OUT_WIDTH-1:0] head_nxt;

  always_comb begin
    full       = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    rd         = out_valid && out_ready;
    // A read on a full FIFO frees the slot the same cycle's write uses
    wr         = s2_v && (!full || rd);
    drop       = s2_v && !wr;
    rd_ptr_nxt = rd_ptr + PW'(rd);
    wr_ptr_nxt = wr_ptr + PW'(wr);
    // The new head is the sample being written when the FIFO was empty after the read
    if (wr && (rd_ptr_nxt[AW-1:0] == wr_ptr[AW-1:0])) begin
      head_nxt = s2_data;
    end else begin
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  // FIFO storage needs no reset; visibility is controlled by the pointers
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr[AW-1:0]] <= s2_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v       <= 1'b0;
      s1_data    <= '0;
      s2_v       <= 1'b0;
      s2_data    <= '0;
      s2_sat     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      fifo_level <= '0;
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      s1_v       <= in_valid;
      s1_data    <= s1_next;
      s2_v       <= s1_v;
      s2_data    <= s2_next;
      s2_sat     <= s2_sat_next;
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      out_valid  <= (wr_ptr_nxt != rd_ptr_nxt);
      fifo_level <= wr_ptr_nxt - rd_ptr_nxt;
      if (wr_ptr_nxt != rd_ptr_nxt) begin
        out_data <= head_nxt;
      end
      if (s2_v && s2_sat && (sat_count != '1)) begin
        sat_count <= sat_count + CNT_WIDTH'(1);
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
